// File: rtl/dvp_axis_cap.sv
// dvp_axis_cap: parallel-camera (DVP) capture to AXI4-Stream master.
//
// Samples FV/LV/D_IN on pclk, packs PPC pixels per beat (first pixel in the LSBs),
// marks the first beat of a frame on tuser and the last beat of a line on tlast,
// and buffers beats in a first-word-fall-through FIFO to absorb backpressure.
//
// Optional feature macro: CAP_LINE_CHECK_EN
//   defined   : line length / line count checking, pixels beyond WIDTH discarded,
//               tlast forced on the beat completing pixel WIDTH.
//   undefined : err_line_len / err_line_cnt tied 0, every pixel while LV is high
//               is captured, tlast marks the beat at the LV fall.
//
// Ports:
//   pclk, resetn            pixel clock, asynchronous active-low reset
//   enable                  capture enable, sampled at FV rise
//   err_clr                 one-cycle pulse clearing the sticky error flags
//   FV, LV, D_IN            sensor frame valid, line valid, pixel data
//   m_axis_t*               AXI4-Stream master (tuser = SOF, tlast = EOL)
//   frame_cnt               completed frames, wrapping 16-bit counter
//   err_overflow            sticky: a beat was lost to a full FIFO
//   err_line_len            sticky: a line length differed from WIDTH
//   err_line_cnt            sticky: a frame line count differed from HEIGTH
module dvp_axis_cap #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PPC        = 1,
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGTH     = 480,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  pclk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  err_clr,
  input  logic                  FV,
  input  logic                  LV,
  input  logic [DATA_W-1:0]     D_IN,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [PPC*DATA_W-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [15:0]           frame_cnt,
  output logic                  err_overflow,
  output logic                  err_line_len,
  output logic                  err_line_cnt
);

`ifdef CAP_LINE_CHECK_EN
  localparam bit LineCheck = 1'b1;
`else
  localparam bit LineCheck = 1'b0;
`endif

  localparam int unsigned BeatW = PPC * DATA_W;
  localparam int unsigned IdxW  = (PPC > 1) ? $clog2(PPC) : 1;
  localparam int unsigned PixW  = $clog2(WIDTH + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PPC - 1);

  typedef enum logic [1:0] {StSync, StWaitFrame, StActive, StDrop} state_e;

  state_e state_q;

  // Input register stage and edge detection
  logic              fv_q, fv_qq, lv_q, lv_qq;
  logic [DATA_W-1:0] d_q;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      // FV history resets high so a frame already in progress never looks like a rise.
      fv_q  <= 1'b1;
      fv_qq <= 1'b1;
      lv_q  <= 1'b0;
      lv_qq <= 1'b0;
      d_q   <= '0;
    end else begin
      fv_q  <= FV;
      fv_qq <= fv_q;
      lv_q  <= LV;
      lv_qq <= lv_q;
      d_q   <= D_IN;
    end
  end

  logic fv_rise, fv_fall, lv_fall, start, capture;
  assign fv_rise = fv_q & ~fv_qq;
  assign fv_fall = ~fv_q & fv_qq;
  assign lv_fall = ~lv_q & lv_qq;
  assign start   = (state_q == StWaitFrame) & fv_rise & enable;
  assign capture = (state_q == StActive) & fv_q & lv_q;

  // Packer
  logic [IdxW-1:0]  pix_idx_q;
  logic [BeatW-1:0] pack_q, pix_ins;
  logic [PixW-1:0]  line_pix_q;
  logic             overlong_q, sof_q;
  logic             wr_v_q, wr_user_q, wr_last_q;
  logic [BeatW-1:0] wr_data_q;
  logic             pix_ok;

  assign pix_ok = !LineCheck || (line_pix_q < PixW'(WIDTH));

  always_comb begin
    pix_ins = pack_q;
    for (int i = 0; i < PPC; i++) begin
      if (pix_idx_q == IdxW'(i)) pix_ins[i*DATA_W +: DATA_W] = d_q;
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      pix_idx_q  <= '0;
      pack_q     <= '0;
      line_pix_q <= '0;
      overlong_q <= 1'b0;
      sof_q      <= 1'b0;
      wr_v_q     <= 1'b0;
      wr_data_q  <= '0;
      wr_user_q  <= 1'b0;
      wr_last_q  <= 1'b0;
    end else begin
      wr_v_q <= 1'b0;
      if (start) begin
        pix_idx_q  <= '0;
        pack_q     <= '0;
        line_pix_q <= '0;
        overlong_q <= 1'b0;
        sof_q      <= 1'b1;
      end else if (state_q != StActive) begin
        pix_idx_q  <= '0;
        pack_q     <= '0;
        line_pix_q <= '0;
        overlong_q <= 1'b0;
      end else if (capture) begin
        if (pix_ok) begin
          line_pix_q <= line_pix_q + 1'b1;
          if (pix_idx_q == LastIdx) begin
            wr_v_q    <= 1'b1;
            wr_data_q <= pix_ins;
            wr_user_q <= sof_q;
            wr_last_q <= LineCheck && (line_pix_q == PixW'(WIDTH - 1));
            sof_q     <= 1'b0;
            pack_q    <= '0;
            pix_idx_q <= '0;
          end else begin
            pack_q    <= pix_ins;
            pix_idx_q <= pix_idx_q + 1'b1;
          end
        end else begin
          overlong_q <= 1'b1;
        end
      end else if (lv_fall) begin
        line_pix_q <= '0;
        overlong_q <= 1'b0;
        pack_q     <= '0;
        pix_idx_q  <= '0;
        // Partial beat: upper pixels are already zero in pack_q.
        if (pix_idx_q != '0) begin
          wr_v_q    <= 1'b1;
          wr_data_q <= pack_q;
          wr_user_q <= sof_q;
          wr_last_q <= 1'b1;
          sof_q     <= 1'b0;
        end
      end
    end
  end

  // FIFO (first-word-fall-through)
  logic [BeatW+1:0] mem [FIFO_DEPTH];
  logic [PtrW:0]    wr_ptr_q, rd_ptr_q;
  logic             empty, full, rd_en, wr_en, push, overflow;
  logic             wr_last_eff;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign rd_en    = ~empty & m_axis_tready;
  assign wr_en    = wr_v_q & (state_q != StDrop);
  assign push     = wr_en & (~full | rd_en);
  assign overflow = wr_en & full & ~rd_en;
  // A full beat followed directly by the LV fall is the last beat of its line.
  assign wr_last_eff = wr_last_q | lv_fall;

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr_q[PtrW-1:0]] <= {wr_user_q, wr_last_eff, wr_data_q};
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  logic [BeatW+1:0] head;
  assign head = empty ? '0 : mem[rd_ptr_q[PtrW-1:0]];
  assign m_axis_tvalid = ~empty;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = head;

  // Frame FSM, counters and sticky flags
  logic [15:0] line_cnt_q, lines_total;
  logic        err_ovf_q, err_len_q, err_cnt_q;
  logic        len_bad, cnt_bad;

  assign lines_total = line_cnt_q + 16'(lv_fall);
  assign len_bad = (state_q == StActive) & lv_fall &
                   ((line_pix_q != PixW'(WIDTH)) | overlong_q);
  assign cnt_bad = (state_q == StActive) & fv_fall & (lines_total != 16'(HEIGTH));

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StSync;
      frame_cnt  <= '0;
      line_cnt_q <= '0;
      err_ovf_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_cnt_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StSync: begin
          if (!fv_q) state_q <= StWaitFrame;
        end
        StWaitFrame: begin
          if (start) begin
            state_q    <= StActive;
            line_cnt_q <= '0;
          end
        end
        StActive: begin
          if (fv_fall) begin
            state_q    <= StWaitFrame;
            line_cnt_q <= '0;
            if (!overflow) frame_cnt <= frame_cnt + 1'b1;
          end else begin
            if (overflow) state_q <= StDrop;
            if (lv_fall) line_cnt_q <= line_cnt_q + 1'b1;
          end
        end
        StDrop: begin
          if (fv_fall) state_q <= StWaitFrame;
        end
        default: state_q <= StSync;
      endcase
      // Set wins over a simultaneous clear.
      err_ovf_q <= overflow | (err_ovf_q & ~err_clr);
      err_len_q <= len_bad  | (err_len_q & ~err_clr);
      err_cnt_q <= cnt_bad  | (err_cnt_q & ~err_clr);
    end
  end

  assign err_overflow = err_ovf_q;
  assign err_line_len = LineCheck & err_len_q;
  assign err_line_cnt = LineCheck & err_cnt_q;

endmodule

// File: tb/tb_dvp_axis_cap.sv
module tb_dvp_axis_cap;

`ifdef CAP_LINE_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b1;
  logic        err_clr = 1'b0;
  logic        FV = 1'b0;
  logic        LV = 1'b0;
  logic [7:0]  D_IN = '0;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tvalid;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [15:0] frame_cnt;
  logic        err_overflow, err_line_len, err_line_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q[$];

  always #5 pclk = ~pclk;

  dvp_axis_cap #(
    .DATA_W    (8),
    .PPC       (2),
    .WIDTH     (8),
    .HEIGTH    (2),
    .FIFO_DEPTH(4)
  ) dut (
    .pclk         (pclk),
    .resetn       (resetn),
    .enable       (enable),
    .err_clr      (err_clr),
    .FV           (FV),
    .LV           (LV),
    .D_IN         (D_IN),
    .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .frame_cnt    (frame_cnt),
    .err_overflow (err_overflow),
    .err_line_len (err_line_len),
    .err_line_cnt (err_line_cnt)
  );

  function automatic logic [31:0] bt(input logic u, input logic l, input logic [15:0] d);
    return {14'd0, u, l, d};
  endfunction

  // Accepted beats, sampled mid-cycle where tvalid/tready are stable.
  always @(negedge pclk) begin
    if (resetn && m_axis_tvalid && m_axis_tready)
      q.push_back(bt(m_axis_tuser, m_axis_tlast, m_axis_tdata));
  end

  function automatic logic [31:0] beat_at(input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic send_line(input int len, input logic [7:0] first);
    for (int i = 0; i < len; i++) begin
      LV   = 1'b1;
      D_IN = 8'(first + 8'(i));
      tick(1);
    end
    LV   = 1'b0;
    D_IN = '0;
    tick(3);
  endtask

  // Line 0 has len0 pixels from b0; further lines have 8 pixels from b1, b1+8, ...
  task automatic send_frame(input int nlines, input int len0, input logic [7:0] b0,
                            input logic [7:0] b1);
    FV = 1'b1;
    tick(3);
    for (int l = 0; l < nlines; l++) begin
      if (l == 0) send_line(len0, b0);
      else send_line(8, 8'(b1 + 8'((l - 1) * 8)));
    end
    FV = 1'b0;
    tick(6);
  endtask

  task automatic chk_full_frame(input string tag);
    chk({tag, "_n"}, q.size(), 8);
    chk({tag, "_b0"}, beat_at(0), bt(1'b1, 1'b0, 16'h0201));
    chk({tag, "_b3"}, beat_at(3), bt(1'b0, 1'b1, 16'h0807));
    chk({tag, "_b4"}, beat_at(4), bt(1'b0, 1'b0, 16'h0a09));
    chk({tag, "_b7"}, beat_at(7), bt(1'b0, 1'b1, 16'h100f));
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_errs", {err_overflow, err_line_len, err_line_cnt}, 0);
    resetn = 1'b1;
    tick(4);

    // Nominal frame: pixels 0x01..0x10, two lines of 8
    send_frame(2, 8, 8'h01, 8'h09);
    chk("t1_n", q.size(), 8);
    chk("t1_b0", beat_at(0), bt(1'b1, 1'b0, 16'h0201));
    chk("t1_b1", beat_at(1), bt(1'b0, 1'b0, 16'h0403));
    chk("t1_b2", beat_at(2), bt(1'b0, 1'b0, 16'h0605));
    chk("t1_b3", beat_at(3), bt(1'b0, 1'b1, 16'h0807));
    chk("t1_b4", beat_at(4), bt(1'b0, 1'b0, 16'h0a09));
    chk("t1_b5", beat_at(5), bt(1'b0, 1'b0, 16'h0c0b));
    chk("t1_b6", beat_at(6), bt(1'b0, 1'b0, 16'h0e0d));
    chk("t1_b7", beat_at(7), bt(1'b0, 1'b1, 16'h100f));
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_errs", {err_overflow, err_line_len, err_line_cnt}, 0);
    chk("t1_idle", m_axis_tvalid, 0);

    // Reset asserted and released while FV is high: rest of that frame ignored
    FV = 1'b1;
    tick(3);
    send_line(8, 8'h01);
    resetn = 1'b0;
    tick(2);
    chk("t2_rst_cnt", frame_cnt, 0);
    resetn = 1'b1;
    q.delete();
    send_line(8, 8'h09);
    FV = 1'b0;
    tick(6);
    chk("t2_no_beats", q.size(), 0);
    chk("t2_no_frame", frame_cnt, 0);
    send_frame(2, 8, 8'h01, 8'h09);
    chk_full_frame("t2");
    chk("t2_frame_cnt", frame_cnt, 1);

    // Short line of 5 pixels, then a full line
    q.delete();
    send_frame(2, 5, 8'h01, 8'h11);
    chk("t3_n", q.size(), 7);
    chk("t3_b0", beat_at(0), bt(1'b1, 1'b0, 16'h0201));
    chk("t3_b1", beat_at(1), bt(1'b0, 1'b0, 16'h0403));
    chk("t3_b2", beat_at(2), bt(1'b0, 1'b1, 16'h0005));
    chk("t3_b6", beat_at(6), bt(1'b0, 1'b1, 16'h1817));
    chk("t3_err_len", err_line_len, 32'(LC));
    chk("t3_err_cnt", err_line_cnt, 0);
    chk("t3_frame_cnt", frame_cnt, 2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk("t3_err_clr", err_line_len, 0);

    // Three lines against HEIGTH=2
    q.delete();
    send_frame(3, 8, 8'h01, 8'h09);
    chk("t6_n", q.size(), 12);
    chk("t6_b11", beat_at(11), bt(1'b0, 1'b1, 16'h1817));
    chk("t6_err_cnt", err_line_cnt, 32'(LC));
    chk("t6_err_len", err_line_len, 0);
    chk("t6_frame_cnt", frame_cnt, 3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk("t6_err_clr", err_line_cnt, 0);

    // enable low at FV rise, raised mid-frame: nothing until the next frame
    q.delete();
    enable = 1'b0;
    FV = 1'b1;
    tick(3);
    send_line(8, 8'h01);
    enable = 1'b1;
    send_line(8, 8'h09);
    FV = 1'b0;
    tick(6);
    chk("t5_no_beats", q.size(), 0);
    chk("t5_no_frame", frame_cnt, 3);
    send_frame(2, 8, 8'h01, 8'h09);
    chk_full_frame("t5");
    chk("t5_frame_cnt", frame_cnt, 4);

    // Backpressure for a whole frame: 4 beats kept, overflow, frame dropped
    q.delete();
    m_axis_tready = 1'b0;
    send_frame(2, 8, 8'h01, 8'h09);
    chk("t4_none_taken", q.size(), 0);
    chk("t4_tvalid", m_axis_tvalid, 1);
    chk("t4_held_data", m_axis_tdata, 16'h0201);
    chk("t4_err_ovf", err_overflow, 1);
    chk("t4_frame_cnt", frame_cnt, 4);
    m_axis_tready = 1'b1;
    tick(10);
    chk("t4_drain_n", q.size(), 4);
    chk("t4_d0", beat_at(0), bt(1'b1, 1'b0, 16'h0201));
    chk("t4_d1", beat_at(1), bt(1'b0, 1'b0, 16'h0403));
    chk("t4_d2", beat_at(2), bt(1'b0, 1'b0, 16'h0605));
    chk("t4_d3", beat_at(3), bt(1'b0, 1'b1, 16'h0807));
    chk("t4_empty", m_axis_tvalid, 0);
    // Clear coinciding with no new event
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk("t4_err_clr", err_overflow, 0);
    q.delete();
    send_frame(2, 8, 8'h01, 8'h09);
    chk_full_frame("t4_next");
    chk("t4_next_frame_cnt", frame_cnt, 5);
    chk("t4_next_no_ovf", err_overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
